// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared encodings for the iterative shifter and the control FSM that drives
//   it: des_op command codes, shifter state encoding and the shift-amount width.
//   No ports (package).
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [2:0] {
    DES_NOP  = 3'd0,
    DES_LOAD = 3'd1,
    DES_SLL  = 3'd2,
    DES_SRL  = 3'd3,
    DES_SRA  = 3'd4,
    DES_ROR  = 3'd5
  } des_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } shift_state_e;

  // Shift amounts come from a 5-bit shamt / rs[4:0] field.
  localparam int SHAMT_W = 5;

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational single step of the iterative shifter: shifts value by s bits
//   according to op (SLL, SRL, SRA, ROR). Any other op passes value through.
// Ports:
//   op     in   3        shift command (des_op encoding)
//   value  in   WIDTH    current shift register contents
//   s      in   SHAMT_W  bits to shift this step (0..STEP)
//   result out  WIDTH    shifted value
// -----------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   value,
  input  logic [SHAMT_W-1:0] s,
  output logic [WIDTH-1:0]   result
);

  logic signed [WIDTH-1:0] value_s;

  always_comb begin
    value_s = value;
    result  = value;
    case (op)
      DES_SLL: result = value << s;
      DES_SRL: result = value >> s;
      // Arithmetic shift replicates the current bit WIDTH-1, so the sign is
      // preserved across successive steps.
      DES_SRA: result = value_s >>> s;
      // Rotate: bits leaving bit 0 re-enter at the top.
      DES_ROR: result = WIDTH'({value, value} >> s);
      default: result = value;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
//   Iterative shifter for the multicycle datapath. A LOAD latches the operand
//   and the shift amount; a following shift command shifts STEP bits per cycle
//   until the amount is exhausted, then pulses done for one cycle. des_out
//   feeds the write-back mux.
//   Optional feature: define SHIFT_ROTATE_EN to make des_op=5 a rotate right;
//   otherwise op 5 is ignored like a NOP.
// Parameters:
//   WIDTH  datapath width (32)
//   STEP   bits shifted per cycle (1, 2, 4, 8 or 16)
// Ports:
//   clk      in   1      system clock, rising edge
//   rst      in   1      asynchronous active-low reset
//   des_op   in   3      command (NOP, LOAD, SLL, SRL, SRA, ROR)
//   des_n    in   5      shift amount
//   des_in   in   WIDTH  operand
//   des_out  out  WIDTH  shift register contents
//   busy     out  1      shift in progress
//   done     out  1      one-cycle pulse, result valid on des_out
// -----------------------------------------------------------------------------
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       des_op,
  input  logic [4:0]       des_n,
  input  logic [WIDTH-1:0] des_in,
  output logic [WIDTH-1:0] des_out,
  output logic             busy,
  output logic             done
);

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  shift_state_e       state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  // Last accepted shift op; also selects the operation while in SHIFT.
  logic [2:0]         last_op_q, last_op_d;
  logic [SHAMT_W-1:0] step_amt;
  logic [WIDTH-1:0]   step_out;

  function automatic logic is_shift_op(input logic [2:0] op);
    case (op)
      DES_SLL, DES_SRL, DES_SRA: return 1'b1;
`ifdef SHIFT_ROTATE_EN
      DES_ROR:                   return 1'b1;
`else
      DES_ROR:                   return 1'b0;
`endif
      default:                   return 1'b0;
    endcase
  endfunction

  // Final step may be shorter than STEP when the remaining count is smaller.
  always_comb begin
    step_amt = (cnt_q < STEP_AMT) ? cnt_q : STEP_AMT;
  end

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op     (last_op_q),
    .value  (data_q),
    .s      (step_amt),
    .result (step_out)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    last_op_d = last_op_q;

    // Seeing NOP or LOAD re-arms the edge detector, so the same shift op can
    // run again. Inputs are ignored entirely while shifting.
    if (state_q != SHIFT && (des_op == DES_NOP || des_op == DES_LOAD)) begin
      last_op_d = DES_NOP;
    end

    case (state_q)
      IDLE: begin
        if (des_op == DES_LOAD) begin
          data_d  = des_in;
          cnt_d   = des_n;
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (des_op == DES_LOAD) begin
          data_d = des_in;
          cnt_d  = des_n;
        end else if (is_shift_op(des_op) && des_op != last_op_q) begin
          last_op_d = des_op;
          state_d   = (cnt_q == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step_out;
        cnt_d  = cnt_q - step_amt;
        // Leave on the step that exhausts the count: ceil(n/STEP) shift
        // cycles after the accept cycle.
        if (cnt_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = LOADED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      last_op_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      last_op_q <= last_op_d;
    end
  end

  assign des_out = data_q;
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  des_op;
  logic [4:0]  des_n;
  logic [31:0] des_in;
  logic [31:0] out1, out4;
  logic        busy1, busy4, done1, done4;

  int n_chk;
  int n_pass;

  shift_unit #(.WIDTH(32), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .des_op(des_op), .des_n(des_n), .des_in(des_in),
    .des_out(out1), .busy(busy1), .done(done1)
  );

  shift_unit #(.WIDTH(32), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .des_op(des_op), .des_n(des_n), .des_in(des_in),
    .des_out(out4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (index 0: STEP=1, index 1: STEP=4)
  localparam int P_IDLE = 0, P_LOADED = 1, P_RUN = 2, P_DONE = 3;
  int          m_phase [2];
  logic [31:0] m_val   [2];
  logic [31:0] m_base  [2];
  int          m_n     [2];
  logic [2:0]  m_last  [2];
  logic [2:0]  m_op    [2];
  int          m_c     [2];
  int          m_t     [2];

  function automatic int stp(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic bit tb_is_shift(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
    return (op >= 3'd2 && op <= 3'd5);
`else
    return (op >= 3'd2 && op <= 3'd4);
`endif
  endfunction

  // Whole shift of v by n bits, from the arithmetic rules.
  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] v, input int n);
    logic [31:0] fill;
    if (n == 0) return v;
    case (op)
      3'd2: return v << n;
      3'd3: return v >> n;
      3'd4: begin
        fill = v[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0;
        return (v >> n) | fill;
      end
      3'd5: return (v >> n) | (v << (32 - n));
      default: return v;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = P_IDLE; m_val[k] = '0; m_base[k] = '0; m_n[k] = 0;
      m_last[k] = '0; m_op[k] = '0; m_c[k] = 0; m_t[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int s;
    int ph;
    s  = stp(k);
    ph = m_phase[k];
    case (ph)
      P_IDLE: if (des_op == 3'd1) begin
        m_val[k] = des_in; m_n[k] = int'(des_n); m_phase[k] = P_LOADED;
      end
      P_LOADED: begin
        if (des_op == 3'd1) begin
          m_val[k] = des_in; m_n[k] = int'(des_n);
        end else if (tb_is_shift(des_op) && des_op != m_last[k]) begin
          m_last[k] = des_op; m_op[k] = des_op; m_base[k] = m_val[k];
          m_t[k] = (m_n[k] + s - 1) / s + 1;
          m_c[k] = 1;
          m_phase[k] = (m_t[k] == 1) ? P_DONE : P_RUN;
        end
      end
      P_RUN: begin
        m_c[k]++;
        if (m_c[k] == m_t[k]) begin
          m_val[k] = ref_shift(m_op[k], m_base[k], m_n[k]);
          m_n[k] = 0;
          m_phase[k] = P_DONE;
        end
      end
      default: m_phase[k] = P_LOADED;
    endcase
    if (ph != P_RUN && (des_op == 3'd0 || des_op == 3'd1)) m_last[k] = '0;
  endtask

  function automatic logic [31:0] exp_out(input int k);
    int done_bits;
    if (m_phase[k] == P_RUN) begin
      done_bits = (m_c[k] - 1) * stp(k);
      if (done_bits > m_n[k]) done_bits = m_n[k];
      return ref_shift(m_op[k], m_base[k], done_bits);
    end
    return m_val[k];
  endfunction

  // ---------------- checking helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic compare_all();
    chk("u1_des_out", out1, exp_out(0));
    chk("u1_busy", 32'(busy1), 32'(m_phase[0] == P_RUN));
    chk("u1_done", 32'(done1), 32'(m_phase[0] == P_DONE));
    chk("u4_des_out", out4, exp_out(1));
    chk("u4_busy", 32'(busy4), 32'(m_phase[1] == P_RUN));
    chk("u4_done", 32'(done4), 32'(m_phase[1] == P_DONE));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] din, input logic [4:0] n);
    des_op = op; des_in = din; des_n = n;
  endtask

  task automatic async_reset();
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    cyc();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [4:0]  n;
    logic [2:0]  op;
    logic [31:0] exp;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat1, lat4, cnt1, cnt4, r;
    logic [2:0] op;
    n_chk = 0; n_pass = 0;

    vecs[0] = '{32'h0000_00F0, 5'd4,  3'd2, 32'h0000_0F00, 5,  2};
    vecs[1] = '{32'h8000_0010, 5'd4,  3'd4, 32'hF800_0001, 5,  2};
    vecs[2] = '{32'h8000_0010, 5'd4,  3'd3, 32'h0800_0001, 5,  2};
    vecs[3] = '{32'h1234_5678, 5'd0,  3'd2, 32'h1234_5678, 1,  1};
    vecs[4] = '{32'hFFFF_FFFF, 5'd31, 3'd2, 32'h8000_0000, 32, 9};
    vecs[5] = '{32'h8000_0000, 5'd31, 3'd4, 32'hFFFF_FFFF, 32, 9};
    vecs[6] = '{32'h8000_0000, 5'd31, 3'd3, 32'h0000_0001, 32, 9};
    vecs[7] = '{32'hA5A5_A5A5, 5'd8,  3'd4, 32'hFFA5_A5A5, 9,  3};

    // reset state, applied asynchronously before any clock edge
    rst = 1'b0;
    drive(3'd0, 32'h0, 5'd0);
    model_reset();
    #1;
    compare_all();
    cyc();
    cyc();
    rst = 1'b1;

    // shift op with no prior LOAD is ignored
    drive(3'd2, 32'hDEAD_BEEF, 5'd3);
    cnt1 = 0; cnt4 = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      cnt1 += int'(done1 | busy1);
      cnt4 += int'(done4 | busy4);
    end
    chk("idle_shift_no_activity_u1", 32'(cnt1), 32'd0);
    chk("idle_shift_no_activity_u4", 32'(cnt4), 32'd0);

    // table-driven directed vectors
    foreach (vecs[v]) begin
      drive(3'd0, 32'h0, 5'd0); cyc();
      drive(3'd1, vecs[v].din, vecs[v].n); cyc();
      drive(vecs[v].op, 32'h5555_AAAA, 5'd17);
      lat1 = -1; lat4 = -1;
      for (int e = 1; e <= 40; e++) begin
        cyc();
        if (done1 && lat1 < 0) begin lat1 = e; chk($sformatf("vec%0d_u1_result", v), out1, vecs[v].exp); end
        if (done4 && lat4 < 0) begin lat4 = e; chk($sformatf("vec%0d_u4_result", v), out4, vecs[v].exp); end
      end
      chk($sformatf("vec%0d_u1_latency", v), 32'(lat1), 32'(vecs[v].lat1));
      chk($sformatf("vec%0d_u4_latency", v), 32'(lat4), 32'(vecs[v].lat4));
    end

    // held shift op fires once; LOAD then same op runs again
    drive(3'd0, 32'h0, 5'd0); cyc();
    drive(3'd1, 32'h8000_0010, 5'd4); cyc();
    drive(3'd3, 32'h0, 5'd0);
    cnt1 = 0; cnt4 = 0;
    for (int i = 0; i < 15; i++) begin cyc(); cnt1 += int'(done1); cnt4 += int'(done4); end
    chk("held_op_pulses_u1", 32'(cnt1), 32'd1);
    chk("held_op_pulses_u4", 32'(cnt4), 32'd1);
    drive(3'd1, 32'h8000_0010, 5'd4); cyc();
    drive(3'd3, 32'h0, 5'd0);
    cnt1 = 0; cnt4 = 0;
    for (int i = 0; i < 10; i++) begin cyc(); cnt1 += int'(done1); cnt4 += int'(done4); end
    chk("rearm_pulses_u1", 32'(cnt1), 32'd1);
    chk("rearm_pulses_u4", 32'(cnt4), 32'd1);

    // reset during the third shift cycle of a 31-bit SLL
    drive(3'd0, 32'h0, 5'd0); cyc();
    drive(3'd1, 32'hFFFF_FFFF, 5'd31); cyc();
    drive(3'd2, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk("pre_reset_busy_u1", 32'(busy1), 32'd1);
    chk("pre_reset_busy_u4", 32'(busy4), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_reset_out_u1", out1, 32'h0);
    chk("mid_reset_out_u4", out4, 32'h0);
    chk("mid_reset_busy", 32'({busy1, busy4, done1, done4}), 32'h0);
    model_reset();
    cyc();
    rst = 1'b1;
    cnt1 = 0; cnt4 = 0;
    for (int i = 0; i < 12; i++) begin cyc(); cnt1 += int'(done1); cnt4 += int'(done4); end
    chk("post_reset_no_done_u1", 32'(cnt1), 32'd0);
    chk("post_reset_no_done_u4", 32'(cnt4), 32'd0);

    // op 5: rotate when enabled, ignored otherwise
    drive(3'd0, 32'h0, 5'd0); cyc();
    drive(3'd1, 32'h0000_0001, 5'd1); cyc();
    drive(3'd5, 32'h0, 5'd0);
`ifdef SHIFT_ROTATE_EN
    lat1 = -1; lat4 = -1;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      if (done1 && lat1 < 0) begin lat1 = e; chk("ror_u1_result", out1, 32'h8000_0000); end
      if (done4 && lat4 < 0) begin lat4 = e; chk("ror_u4_result", out4, 32'h8000_0000); end
    end
    chk("ror_u1_latency", 32'(lat1), 32'd2);
    chk("ror_u4_latency", 32'(lat4), 32'd2);
`else
    cnt1 = 0; cnt4 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      cnt1 += int'(done1 | busy1);
      cnt4 += int'(done4 | busy4);
    end
    chk("op5_ignored_u1", 32'(cnt1), 32'd0);
    chk("op5_ignored_u4", 32'(cnt4), 32'd0);
    chk("op5_out_u1", out1, 32'h0000_0001);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset();
      r = int'($urandom_range(0, 9));
      if (r < 2)      op = 3'd0;
      else if (r < 4) op = 3'd1;
      else            op = 3'($urandom_range(2, 7));
      drive(op, $urandom, 5'($urandom_range(0, 31)));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
